// File: rtl/alu_issue_ctrl_if.sv
// ID/hazard-unit to EX-controller bundle for alu_issue_ctrl.
// master drives issue and hazard requests; slave is the EX controller.
interface alu_issue_ctrl_if #(
  parameter int STEP_W = 6
);
  logic              id_valid;
  logic [3:0]        id_op;
  logic              stall_in;
  logic              flush;
  logic              id_stall;
  logic              ex_valid;
  logic [2:0]        ex_cntrl;
  logic              ex_setflags;
  logic              ex_wb_en;
  logic              mul_active;
  logic [STEP_W-1:0] mul_step;
  logic              illegal_op;

  modport master (
    output id_valid, id_op, stall_in, flush,
    input  id_stall, ex_valid, ex_cntrl, ex_setflags, ex_wb_en,
           mul_active, mul_step, illegal_op
  );

  modport slave (
    input  id_valid, id_op, stall_in, flush,
    output id_stall, ex_valid, ex_cntrl, ex_setflags, ex_wb_en,
           mul_active, mul_step, illegal_op
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// EX-stage ALU result-select controller with optional multi-cycle shift-add multiply.
// Multiply sequencing is built only when ALU_ISSUE_MUL_EN is defined; otherwise opcode 9 is illegal.
module alu_issue_ctrl #(
  parameter int MUL_CYCLES = 64,
  parameter int STEP_W     = $clog2(MUL_CYCLES)
) (
  input logic              clk,
  input logic              reset,
  alu_issue_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_PASSB = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_ADDS  = 4'd6,
    OP_SUBS  = 4'd7,
    OP_CMP   = 4'd8,
    OP_MUL   = 4'd9
  } op_e;

  localparam logic [2:0] SEL_PASSB = 3'b000;
  localparam logic [2:0] SEL_ADD   = 3'b010;
  localparam logic [2:0] SEL_SUB   = 3'b011;
  localparam logic [2:0] SEL_AND   = 3'b100;
  localparam logic [2:0] SEL_OR    = 3'b101;
  localparam logic [2:0] SEL_XOR   = 3'b110;

  typedef struct packed {
    logic       valid;
    logic [2:0] cntrl;
    logic       setflags;
    logic       wb_en;
    logic       illegal;
  } ex_t;

  ex_t  ex_q;
  ex_t  acc_d;
  logic acc_mul_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d     = '0;
    acc_mul_d = 1'b0;
    if (bus.id_valid) begin
      case (bus.id_op)
        OP_PASSB: begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_PASSB; acc_d.wb_en = 1'b1; end
        OP_ADD:   begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_ADD;   acc_d.wb_en = 1'b1; end
        OP_SUB:   begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_SUB;   acc_d.wb_en = 1'b1; end
        OP_AND:   begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_AND;   acc_d.wb_en = 1'b1; end
        OP_OR:    begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_OR;    acc_d.wb_en = 1'b1; end
        OP_XOR:   begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_XOR;   acc_d.wb_en = 1'b1; end
        OP_ADDS: begin
          acc_d.valid = 1'b1; acc_d.cntrl = SEL_ADD; acc_d.setflags = 1'b1; acc_d.wb_en = 1'b1;
        end
        OP_SUBS: begin
          acc_d.valid = 1'b1; acc_d.cntrl = SEL_SUB; acc_d.setflags = 1'b1; acc_d.wb_en = 1'b1;
        end
        OP_CMP:   begin acc_d.valid = 1'b1; acc_d.cntrl = SEL_SUB; acc_d.setflags = 1'b1; end
`ifdef ALU_ISSUE_MUL_EN
        // The multiply occupies the shared adder while iterating; nothing retires yet.
        OP_MUL:   begin acc_d.cntrl = SEL_ADD; acc_mul_d = 1'b1; end
`endif
        default:  acc_d.illegal = 1'b1;
      endcase
    end
  end

`ifdef ALU_ISSUE_MUL_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } state_e;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_CYCLES - 1);

  state_e            state_q;
  logic [STEP_W-1:0] mul_step_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
`ifdef ALU_ISSUE_MUL_EN
      state_q    <= IDLE;
      mul_step_q <= '0;
`endif
    end else if (bus.flush) begin
      ex_q <= '0;
`ifdef ALU_ISSUE_MUL_EN
      state_q    <= IDLE;
      mul_step_q <= '0;
`endif
    end else if (bus.stall_in) begin
      ex_q.illegal <= 1'b0;
`ifdef ALU_ISSUE_MUL_EN
    end else if (state_q == MUL_RUN) begin
      if (mul_step_q == LAST_STEP) begin
        // Product is presented on the B path for the single retire cycle.
        ex_q       <= '{valid: 1'b1, cntrl: SEL_PASSB, setflags: 1'b0, wb_en: 1'b1, illegal: 1'b0};
        mul_step_q <= '0;
        state_q    <= MUL_DONE;
      end else begin
        mul_step_q <= mul_step_q + STEP_W'(1);
      end
`endif
    end else begin
      // IDLE and MUL_DONE both accept, so a new op loads on the edge that ends the retire cycle.
      ex_q <= acc_d;
`ifdef ALU_ISSUE_MUL_EN
      mul_step_q <= '0;
      state_q    <= acc_mul_d ? MUL_RUN : IDLE;
`endif
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_cntrl    = ex_q.cntrl;
  assign bus.ex_setflags = ex_q.setflags;
  assign bus.ex_wb_en    = ex_q.wb_en;
  assign bus.illegal_op  = ex_q.illegal;

`ifdef ALU_ISSUE_MUL_EN
  assign bus.mul_active = (state_q == MUL_RUN);
  assign bus.mul_step   = mul_step_q;
  // Masked during reset so an undefined pre-reset state cannot back-pressure ID.
  assign bus.id_stall   = bus.stall_in | (!reset && (state_q == MUL_RUN));
`else
  assign bus.mul_active = 1'b0;
  assign bus.mul_step   = '0;
  assign bus.id_stall   = bus.stall_in;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, multiply corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_alu_issue_ctrl;

  localparam int MC = 4;
  localparam int SW = $clog2(MC);
`ifdef ALU_ISSUE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] PASSB = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                         XOR_ = 4'd5, ADDS = 4'd6, SUBS = 4'd7, CMP = 4'd8, MUL = 4'd9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.STEP_W(SW)) bus ();

  alu_issue_ctrl #(.MUL_CYCLES(MC), .STEP_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       valid;
    bit [2:0] cntrl;
    bit       setf;
    bit       wb;
    bit       ill;
    bit       act;
    int       step;
  } exp_t;

  exp_t m;
  int   m_run = -1;      // index of the multiply iteration in progress, -1 when none
  bit   cntrl_known = 1'b0;

  function automatic exp_t op_result(bit v, logic [3:0] op);
    exp_t e = '{default: 0};
    if (!v) return e;
    case (op)
      PASSB: begin e.valid = 1; e.cntrl = 3'b000; e.wb = 1; end
      ADD:   begin e.valid = 1; e.cntrl = 3'b010; e.wb = 1; end
      SUB:   begin e.valid = 1; e.cntrl = 3'b011; e.wb = 1; end
      AND_:  begin e.valid = 1; e.cntrl = 3'b100; e.wb = 1; end
      OR_:   begin e.valid = 1; e.cntrl = 3'b101; e.wb = 1; end
      XOR_:  begin e.valid = 1; e.cntrl = 3'b110; e.wb = 1; end
      ADDS:  begin e.valid = 1; e.cntrl = 3'b010; e.wb = 1; e.setf = 1; end
      SUBS:  begin e.valid = 1; e.cntrl = 3'b011; e.wb = 1; e.setf = 1; end
      CMP:   begin e.valid = 1; e.cntrl = 3'b011; e.wb = 0; e.setf = 1; end
      MUL:   if (MUL_EN) begin e.cntrl = 3'b010; e.act = 1; end else e.ill = 1;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic model_edge(input bit r, f, s, v, input logic [3:0] op);
    if (r) begin
      m = '{default: 0}; m_run = -1; cntrl_known = 1;
    end else if (f) begin
      m = '{default: 0}; m_run = -1; cntrl_known = 0;
    end else if (s) begin
      m.ill = 0;
    end else if (m_run >= 0) begin
      if (m_run == MC - 1) begin
        m = '{valid: 1, cntrl: 3'b000, setf: 0, wb: 1, ill: 0, act: 0, step: 0};
        m_run = -1; cntrl_known = 1;
      end else begin
        m_run++;
        m.step = m_run;
      end
    end else begin
      m = op_result(v, op);
      m_run = m.act ? 0 : -1;
      cntrl_known = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " ex_valid"},    bus.ex_valid,    m.valid);
    if (cntrl_known) check({tag, " ex_cntrl"}, bus.ex_cntrl, m.cntrl);
    check({tag, " ex_setflags"}, bus.ex_setflags, m.setf);
    check({tag, " ex_wb_en"},    bus.ex_wb_en,    m.wb);
    check({tag, " illegal_op"},  bus.illegal_op,  m.ill);
    check({tag, " mul_active"},  bus.mul_active,  m.act);
    check({tag, " mul_step"},    bus.mul_step,    m.step);
  endtask

  // Called at a negedge; drives one cycle of inputs, checks id_stall, advances one edge.
  task automatic apply(input bit r, f, s, v, input logic [3:0] op);
    reset        = r;
    bus.flush    = f;
    bus.stall_in = s;
    bus.id_valid = v;
    bus.id_op    = op;
    #1;
    check("id_stall", bus.id_stall, r ? s : (s | (m_run >= 0)));
    model_edge(r, f, s, v, op);
    @(posedge clk);
    @(negedge clk);
    check_outputs("model");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       r, f, s, v;
    logic [3:0] op;
    bit       ev;
    logic [2:0] ec;
    bit       es, ew, ei;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, f, s, v, logic [3:0] op, bit ev, logic [2:0] ec, bit es, ew, ei);
    tbl.push_back('{r, f, s, v, op, ev, ec, es, ew, ei});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    reset = 1'b1; bus.flush = 1'b0; bus.stall_in = 1'b0; bus.id_valid = 1'b0; bus.id_op = 4'd0;

    //   r f s v op      ev  ec      es ew ei
    add(1,0,0,1,ADD,    0, 3'b000, 0, 0, 0);
    add(1,0,0,0,PASSB,  0, 3'b000, 0, 0, 0);
    add(0,0,0,1,ADD,    1, 3'b010, 0, 1, 0);
    add(0,0,0,1,SUB,    1, 3'b011, 0, 1, 0);
    add(0,0,0,1,XOR_,   1, 3'b110, 0, 1, 0);
    add(0,0,0,1,PASSB,  1, 3'b000, 0, 1, 0);
    add(0,0,0,1,SUBS,   1, 3'b011, 1, 1, 0);
    add(0,0,0,1,CMP,    1, 3'b011, 1, 0, 0);
    add(0,0,0,1,4'd12,  0, 3'b000, 0, 0, 1);
    add(0,0,0,1,AND_,   1, 3'b100, 0, 1, 0);
    add(0,0,0,1,4'd12,  0, 3'b000, 0, 0, 1);
    add(0,0,1,1,OR_,    0, 3'b000, 0, 0, 0);
    add(0,0,0,1,OR_,    1, 3'b101, 0, 1, 0);
    add(0,0,1,1,XOR_,   1, 3'b101, 0, 1, 0);
    add(0,0,0,1,ADDS,   1, 3'b010, 1, 1, 0);
    add(0,0,0,0,ADD,    0, 3'b000, 0, 0, 0);
    add(0,1,0,1,ADD,    0, 3'b000, 0, 0, 0);
    add(0,0,0,1,4'd15,  0, 3'b000, 0, 0, 1);
    add(0,0,0,1,4'd10,  0, 3'b000, 0, 0, 1);
    add(0,0,0,1,ADD,    1, 3'b010, 0, 1, 0);
    add(0,0,0,1,SUB,    1, 3'b011, 0, 1, 0);
    add(1,0,0,1,SUB,    0, 3'b000, 0, 0, 0);
    add(1,0,0,1,SUB,    0, 3'b000, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].op);
      check($sformatf("tbl%0d ex_valid", i),    bus.ex_valid,    tbl[i].ev);
      check($sformatf("tbl%0d ex_cntrl", i),    bus.ex_cntrl,    tbl[i].ec);
      check($sformatf("tbl%0d ex_setflags", i), bus.ex_setflags, tbl[i].es);
      check($sformatf("tbl%0d ex_wb_en", i),    bus.ex_wb_en,    tbl[i].ew);
      check($sformatf("tbl%0d illegal_op", i),  bus.illegal_op,  tbl[i].ei);
    end

    if (MUL_EN) begin
      // MUL followed by an ADD waiting in ID
      apply(0,0,0,1,MUL);
      check("mulA first active", bus.mul_active, 1);
      check("mulA first cntrl",  bus.ex_cntrl,   3'b010);
      check("mulA first valid",  bus.ex_valid,   0);
      hi = 0;
      for (int i = 0; i < MC; i++) begin
        check($sformatf("mulA step%0d", i), bus.mul_step, i);
        reset = 0; bus.flush = 0; bus.stall_in = 0; bus.id_valid = 1; bus.id_op = ADD;
        #1;
        if (bus.id_stall) hi++;
        apply(0,0,0,1,ADD);
      end
      check("mulA id_stall cycles", hi, MC);
      check("mulA retire valid",  bus.ex_valid,   1);
      check("mulA retire cntrl",  bus.ex_cntrl,   3'b000);
      check("mulA retire wb_en",  bus.ex_wb_en,   1);
      check("mulA retire active", bus.mul_active, 0);
      apply(0,0,0,1,ADD);
      check("mulA add valid", bus.ex_valid, 1);
      check("mulA add cntrl", bus.ex_cntrl, 3'b010);

      // two stall cycles at mul_step==1 delay retirement by exactly two cycles
      apply(0,0,0,1,MUL);
      apply(0,0,0,0,PASSB);
      check("mulS step before stall", bus.mul_step, 1);
      apply(0,0,1,0,PASSB);
      check("mulS step stall1", bus.mul_step, 1);
      apply(0,0,1,0,PASSB);
      check("mulS step stall2", bus.mul_step, 1);
      n = 3;
      while (!bus.ex_valid && n < 20) begin
        apply(0,0,0,0,PASSB);
        n++;
      end
      check("mulS retire edge", n, MC + 2);
      apply(0,0,0,0,PASSB);

      // flush at mul_step==2 aborts; the next MUL restarts from step 0
      apply(0,0,0,1,MUL);
      apply(0,0,0,0,PASSB);
      apply(0,0,0,0,PASSB);
      check("mulF step before flush", bus.mul_step, 2);
      apply(0,1,0,1,ADD);
      check("mulF active", bus.mul_active, 0);
      check("mulF step",   bus.mul_step,   0);
      check("mulF valid",  bus.ex_valid,   0);
      apply(0,0,0,1,MUL);
      check("mulF restart step",   bus.mul_step,   0);
      check("mulF restart active", bus.mul_active, 1);
      n = 0;
      while (!bus.ex_valid && n < 20) begin
        apply(0,0,0,0,PASSB);
        n++;
      end
      check("mulF restart retire edge", n, MC);
    end else begin
      // opcode 9 is illegal without the multiplier
      apply(0,0,0,1,MUL);
      check("op9 illegal",    bus.illegal_op, 1);
      check("op9 valid",      bus.ex_valid,   0);
      check("op9 mul_active", bus.mul_active, 0);
      apply(0,0,1,1,MUL);
      check("op9 stalled illegal", bus.illegal_op, 0);
      apply(0,0,0,1,ADD);
      check("op9 then add illegal", bus.illegal_op, 0);
      check("op9 then add cntrl",   bus.ex_cntrl,   3'b010);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit r, f, s, v;
      logic [3:0] op;
      r  = ($urandom_range(0, 59) == 0);
      f  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 4) == 0);
      v  = ($urandom_range(0, 7) != 0);
      op = ($urandom_range(0, 5) == 0) ? MUL : 4'($urandom_range(0, 15));
      apply(r, f, s, v, op);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- EX-stage controller for the ALU result-select mux.
- Latches the decoded ALU operation from ID into an EX pipeline register and drives the 3-bit result-select control and flag-set enable.
- Handles stall and flush from the hazard unit.
- Sequences a multi-cycle shift-add multiply on the shared adder, back-pressuring ID for its duration.

Parameters:
- MUL_CYCLES, 64, number of adder iterations per multiply; legal range 2..64.
- STEP_W, $clog2(MUL_CYCLES), width of mul_step.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a valid ALU instruction
- id_op  input  4  0 PASSB, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDS, 7 SUBS, 8 CMP, 9 MUL; 10-15 illegal
- stall_in  input  1  hazard-unit stall; freezes EX register and multiply counter
- flush  input  1  squash EX contents and abort any multiply
- id_stall  output  1  combinational: stall_in OR (state==MUL_RUN)
- ex_valid  output  1  EX slot holds a retiring ALU result
- ex_cntrl  output  3  result-select: 000 passB, 010 add, 011 sub, 100 and, 101 or, 110 xor; 001/111 never driven
- ex_setflags  output  1  update NZCV this cycle (ADDS, SUBS, CMP)
- ex_wb_en  output  1  register write-back enable (0 for CMP)
- mul_active  output  1  multiply iteration in progress
- mul_step  output  STEP_W  current iteration index
- illegal_op  output  1  one-cycle pulse, illegal opcode reached EX

Behaviour:
Reset:
- Every output register is 0: ex_cntrl=000, state=IDLE, mul_step=0.
- id_stall = stall_in during reset.

Priority each edge: reset > flush > stall_in > normal advance.

Opcode mapping (latency 1: ID op at edge N appears on EX outputs after edge N):
- PASSB → 000
- ADD, ADDS → 010
- SUB, SUBS, CMP → 011
- AND → 100
- OR → 101
- XOR → 110
- ex_setflags = 1 for ADDS, SUBS, CMP.
- ex_wb_en = ex_valid AND not CMP.

Acceptance:
- Occurs when state is IDLE or MUL_DONE and stall_in=0.
- id_valid=0 loads a bubble: ex_valid=0, ex_cntrl=000, flags 0.

Illegal opcode:
- Loads a bubble and illegal_op=1 for exactly one cycle.
- No state change.

stall_in=1:
- All EX registers, state and mul_step hold.
- illegal_op holds 0; the pulse is not repeated.

flush=1:
- Next cycle ex_valid=0, ex_setflags=0, ex_wb_en=0, illegal_op=0, mul_active=0, mul_step=0, state=IDLE.
- The ID instruction presented that cycle is not accepted.

FSM:
- IDLE: accept per above. MUL accepted → MUL_RUN, with ex_valid=0, ex_cntrl=010, mul_active=1, mul_step=0.
- MUL_RUN:
  - Each unstalled cycle: mul_step += 1, ex_cntrl stays 010, ex_valid stays 0.
  - At mul_step==MUL_CYCLES-1 with no stall → MUL_DONE: ex_valid=1, ex_cntrl=000 (product passed via B), ex_wb_en=1, mul_active=0, mul_step=0.
- MUL_DONE: lasts one cycle. Behaves as IDLE for acceptance, so a new op (or a back-to-back MUL) loads on the same edge that ends MUL_DONE. With no new MUL → IDLE.
- A multiply occupies exactly MUL_CYCLES+1 EX cycles (MUL_CYCLES of mul_active, plus one retire) absent stalls. Each stall cycle adds exactly one.
- mul_step never exceeds MUL_CYCLES-1 and does not wrap.

Optional Feature:
- Macro: ALU_ISSUE_MUL_EN.
- Defined: opcode 9 sequences a multiply as above.
- Undefined:
  - Opcode 9 is illegal (bubble + illegal_op pulse).
  - MUL_RUN and MUL_DONE are not built.
  - mul_active and mul_step are tied to 0.
  - id_stall = stall_in.

Test Plan:
- Reset held 2 cycles mid-stream, then ADD, SUB, XOR, PASSB on consecutive cycles → cycle after each: ex_cntrl 010, 011, 110, 000, ex_valid=1, ex_setflags=0.
- SUBS, then CMP → ex_cntrl 011 both. ex_setflags=1 both. ex_wb_en 1 then 0.
- id_op=12 → one bubble, illegal_op high exactly 1 cycle. With macro undefined, id_op=9 behaves the same.
- MUL with MUL_CYCLES=4, then ADD waiting in ID:
  - id_stall high 4 cycles; mul_step 0,1,2,3.
  - Retire cycle: ex_valid=1, ex_cntrl=000.
  - ADD retires the following cycle.
- MUL with stall_in pulsed 2 cycles at mul_step=1 → mul_step holds at 1; retire delayed exactly 2 cycles.
- flush asserted at mul_step=2 → next cycle mul_active=0, mul_step=0, ex_valid=0, state IDLE; next MUL restarts from step 0.
